serial_word_tx: RTL and testbench

//   Parallel-to-serial transmitter that feeds the serial two's-complementer.

---
 rtl/serial_word_tx.sv | 107 ++++++++++
 tb/tb_serial_word_tx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_tx.sv
// LSB-first parallel-to-serial transmitter with a per-word frame strobe (fr) and
// last-bit flag, accepting words over valid/ready with zero-gap back-to-back support.
module serial_word_tx #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             t_clock,
  input  logic             r,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [W-1:0]     load_data,
  output logic             x,
  output logic             fr,
  output logic             last,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [W-1:0]     sh_q, sh_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fr_q, fr_d;
  logic             last_q, last_d;
  logic             busy_q, busy_d;
  logic             accept;

  // Handshake: a word is taken on any rising edge where load_valid && load_ready.
  // load_ready is high in IDLE and during the final bit of a word, so a new word
  // can follow the previous one with no idle cycle.
  assign load_ready = (state_q == IDLE) || last_q;
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sh_d    = load_data;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (idx_q == LAST_IDX) begin
          cnt_d = cnt_q + 1'b1;
          if (accept) begin
            sh_d  = load_data;
            idx_d = '0;
          end else begin
            // Clearing sh forces x low while idle.
            sh_d    = '0;
            idx_d   = '0;
            state_d = IDLE;
          end
        end else begin
          sh_d  = sh_q >> 1;
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        sh_d    = '0;
        idx_d   = '0;
        state_d = IDLE;
      end
    endcase
    fr_d   = (state_d == SEND) && (idx_d == '0);
    last_d = (state_d == SEND) && (idx_d == LAST_IDX);
    busy_d = (state_d == SEND);
  end

  always_ff @(posedge t_clock or posedge r) begin
    if (r) begin
      state_q <= IDLE;
      sh_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      fr_q    <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      fr_q    <= fr_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  // Status flags come straight from flops so they cannot glitch.
  assign x        = sh_q[0];
  assign fr       = fr_q;
  assign last     = last_q;
  assign busy     = busy_q;
  assign word_cnt = cnt_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: single words, back-to-back, data churn,
// async reset mid-word, complementer chain, counter wrap and the W=1 build.
module tb_serial_word_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       r;
  logic       load_valid, load_ready, x, fr, last, busy;
  logic [7:0] load_data, word_cnt;

  logic       c2_valid, c2_ready, c2_x, c2_fr, c2_last, c2_busy;
  logic [7:0] c2_data;
  logic [1:0] c2_cnt;

  logic       w1_valid, w1_ready, w1_x, w1_fr, w1_last, w1_busy;
  logic [0:0] w1_data;
  logic [7:0] w1_cnt;

  serial_word_tx #(.W(8), .CNT_W(8)) dut (
    .t_clock(clk), .r(r), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .x(x), .fr(fr), .last(last), .busy(busy),
    .word_cnt(word_cnt)
  );

  serial_word_tx #(.W(8), .CNT_W(2)) dut_c2 (
    .t_clock(clk), .r(r), .load_valid(c2_valid), .load_ready(c2_ready),
    .load_data(c2_data), .x(c2_x), .fr(c2_fr), .last(c2_last), .busy(c2_busy),
    .word_cnt(c2_cnt)
  );

  serial_word_tx #(.W(1), .CNT_W(8)) dut_w1 (
    .t_clock(clk), .r(r), .load_valid(w1_valid), .load_ready(w1_ready),
    .load_data(w1_data), .x(w1_x), .fr(w1_fr), .last(w1_last), .busy(w1_busy),
    .word_cnt(w1_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    r = 1'b1;
    tick();
    r = 1'b0;
  endtask

  logic [15:0] pat;
  logic        seen, y;
  logic [1:0]  c2_exp;

  initial begin
    r = 1'b1;
    load_valid = 1'b0; load_data = 8'h00;
    c2_valid = 1'b0;   c2_data = 8'h00;
    w1_valid = 1'b0;   w1_data = 1'b0;

    // Reset state, observed while r is held.
    #2;
    check("rst_x", 32'(x), 32'd0);
    check("rst_fr", 32'(fr), 32'd0);
    check("rst_last", 32'(last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cnt", 32'(word_cnt), 32'd0);
    @(negedge clk);
    r = 1'b0;
    check("rst_ready", 32'(load_ready), 32'd1);

    // Test 1: single word 8'hA6.
    pat = 16'h00A6;
    load_valid = 1'b1; load_data = 8'hA6;
    tick();
    load_valid = 1'b0; load_data = 8'h55;
    for (int i = 0; i < 8; i++) begin
      check("t1_x", 32'(x), 32'(pat[i]));
      check("t1_fr", 32'(fr), 32'(i == 0));
      check("t1_last", 32'(last), 32'(i == 7));
      check("t1_busy", 32'(busy), 32'd1);
      tick();
    end
    check("t1_idle_x", 32'(x), 32'd0);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_idle_fr", 32'(fr), 32'd0);
    check("t1_cnt", 32'(word_cnt), 32'd1);

    // Test 2: 8'h01 then 8'hFF back-to-back.
    do_reset();
    pat = 16'hFF01;
    load_valid = 1'b1; load_data = 8'h01;
    tick();
    load_data = 8'hFF;
    for (int i = 0; i < 16; i++) begin
      check("t2_x", 32'(x), 32'(pat[i]));
      check("t2_fr", 32'(fr), 32'(i == 0 || i == 8));
      check("t2_ready", 32'(load_ready), 32'(i == 7 || i == 15));
      if (i == 15) load_valid = 1'b0;
      tick();
    end
    check("t2_cnt", 32'(word_cnt), 32'd2);
    check("t2_busy", 32'(busy), 32'd0);

    // Test 3: load_data churns while sending; only the last-cycle value is taken.
    do_reset();
    pat = 16'hC53C;
    load_valid = 1'b1; load_data = 8'h3C;
    tick();
    for (int i = 0; i < 16; i++) begin
      check("t3_x", 32'(x), 32'(pat[i]));
      if (i < 7) begin
        load_valid = 1'b1;
        load_data  = 8'(8'h11 * (i + 1));
      end else if (i == 7) begin
        load_data = 8'hC5;
      end else begin
        load_valid = 1'b0;
        load_data  = 8'(i);
      end
      tick();
    end
    check("t3_cnt", 32'(word_cnt), 32'd2);

    // Test 4: async reset mid-word, then a clean frame.
    load_valid = 1'b1; load_data = 8'hFF;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("t4_pre_x", 32'(x), 32'd1);
    #2 r = 1'b1;
    #1;
    check("t4_async_x", 32'(x), 32'd0);
    check("t4_async_fr", 32'(fr), 32'd0);
    check("t4_async_last", 32'(last), 32'd0);
    check("t4_async_busy", 32'(busy), 32'd0);
    check("t4_async_cnt", 32'(word_cnt), 32'd0);
    @(negedge clk);
    r = 1'b0;
    check("t4_ready", 32'(load_ready), 32'd1);
    pat = 16'h005A;
    load_valid = 1'b1; load_data = 8'h5A;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t4_x", 32'(x), 32'(pat[i]));
      check("t4_fr", 32'(fr), 32'(i == 0));
      check("t4_last", 32'(last), 32'(i == 7));
      tick();
    end
    check("t4_cnt", 32'(word_cnt), 32'd1);

    // Test 5: serial two's-complementer model fed by x/fr.
    do_reset();
    pat  = 16'h00FA;
    seen = 1'b0;
    load_valid = 1'b1; load_data = 8'h06;
    tick();
    load_data = 8'h00;
    for (int i = 0; i < 16; i++) begin
      if (fr) seen = 1'b0;
      y = seen ? ~x : x;
      if (x) seen = 1'b1;
      check("t5_y", 32'(y), 32'(pat[i]));
      if (i == 8) load_valid = 1'b0;
      tick();
    end
    check("t5_cnt", 32'(word_cnt), 32'd2);

    // Test 6a: CNT_W=2 counter wraps.
    for (int k = 0; k < 5; k++) begin
      c2_valid = 1'b1; c2_data = 8'(k);
      tick();
      c2_valid = 1'b0;
      for (int j = 0; j < 8; j++) tick();
      c2_exp = 2'(k + 1);
      check("t6_c2_cnt", 32'(c2_cnt), 32'(c2_exp));
      check("t6_c2_idle", 32'({c2_x, c2_fr, c2_last, c2_busy, c2_ready}), 32'b00001);
    end

    // Test 6b: W=1, bits 1,0,1 back-to-back.
    pat = 16'h0005;
    w1_valid = 1'b1; w1_data = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t6_w1_x", 32'(w1_x), 32'(pat[i]));
      check("t6_w1_frlast", 32'({w1_fr, w1_last, w1_busy, w1_ready}), 32'b1111);
      if (i == 0) w1_data = 1'b0;
      else if (i == 1) w1_data = 1'b1;
      else w1_valid = 1'b0;
      tick();
    end
    check("t6_w1_idle", 32'({w1_x, w1_fr, w1_last, w1_busy}), 32'd0);
    check("t6_w1_cnt", 32'(w1_cnt), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
